// File: rtl/h_alpha_stream_rx.sv
// h_alpha_stream_rx
// Receives one frame made of I rows of H (J bits each) and A alpha words
// (DW bits each). The two AXI-stream-style inputs are independent and may
// interleave arbitrarily. The frame ends when both counts are complete;
// tlast does not end a frame.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   start                        arms reception of one frame (honoured only in IDLE)
//   H_row / _tvalid / _tlast     H stream input; H_row_tready is the accept output
//   alpha_u_col / _tvalid / _tlast / _tready   alpha stream, same handshake
//   h_rd_addr -> h_rd_data       combinational H buffer read (out of range returns 0)
//   a_rd_addr -> a_rd_data       combinational alpha buffer read (out of range returns 0)
//   frame_done                   one-cycle pulse in the DONE state
//   busy                         high in RECV and DONE
//   err                          sticky tlast framing error
//
// Build option: define RX_TLAST_CHECK_EN to enable the tlast framing check.
// Without it, err is tied to 0 and the tlast inputs are ignored.
//
// state | meaning
// IDLE  | waiting for start, both streams stalled
// RECV  | accepting H and alpha beats until both counts are complete
// DONE  | frame complete, frame_done pulse, back to IDLE next cycle
module h_alpha_stream_rx #(
   parameter int J  = 14,
   parameter int I  = 2,
   parameter int A  = 2,
   parameter int DW = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [J-1:0]         H_row,
   input  logic                 H_row_tvalid,
   input  logic                 H_row_tlast,
   output logic                 H_row_tready,
   input  logic [DW-1:0]        alpha_u_col,
   input  logic                 alpha_u_col_tvalid,
   input  logic                 alpha_u_col_tlast,
   output logic                 alpha_u_col_tready,
   input  logic [$clog2(I):0]   h_rd_addr,
   output logic [J-1:0]         h_rd_data,
   input  logic [$clog2(A):0]   a_rd_addr,
   output logic [DW-1:0]        a_rd_data,
   output logic                 frame_done,
   output logic                 busy,
   output logic                 err
);

   localparam int HAW = $clog2(I) + 1;
   localparam int AAW = $clog2(A) + 1;

   localparam logic [HAW-1:0] H_FULL = HAW'(I);
   localparam logic [HAW-1:0] H_LAST = HAW'(I - 1);
   localparam logic [HAW-1:0] H_ONE  = HAW'(1);
   localparam logic [AAW-1:0] A_FULL = AAW'(A);
   localparam logic [AAW-1:0] A_LAST = AAW'(A - 1);
   localparam logic [AAW-1:0] A_ONE  = AAW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [HAW-1:0]   h_cnt;
   logic [AAW-1:0]   a_cnt;
   logic             h_fire;
   logic             a_fire;
   logic             h_full_nx;
   logic             a_full_nx;
   logic [J-1:0]     h_buf [I];
   logic [DW-1:0]    a_buf [A];

   // Handshakes can only fire in RECV because both treadys are gated by state.
   assign h_fire = H_row_tvalid & H_row_tready;
   assign a_fire = alpha_u_col_tvalid & alpha_u_col_tready;

   // Look ahead to the post-edge count so DONE follows the final beat directly.
   assign h_full_nx = (h_cnt == H_FULL) | (h_fire & (h_cnt == H_LAST));
   assign a_full_nx = (a_cnt == A_FULL) | (a_fire & (a_cnt == A_LAST));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RECV;
         RECV:    if (h_full_nx && a_full_nx) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      H_row_tready       = 1'b0;
      alpha_u_col_tready = 1'b0;
      busy               = 1'b0;
      frame_done         = 1'b0;
      case (state)
         RECV: begin
            H_row_tready       = (h_cnt < H_FULL);
            alpha_u_col_tready = (a_cnt < A_FULL);
            busy               = 1'b1;
         end
         DONE: begin
            busy       = 1'b1;
            frame_done = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt <= '0;
         a_cnt <= '0;
      end else if (state == IDLE && start) begin
         h_cnt <= '0;
         a_cnt <= '0;
      end else begin
         if (h_fire) h_cnt <= h_cnt + H_ONE;
         if (a_fire) a_cnt <= a_cnt + A_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < I; k++) h_buf[k] <= '0;
         for (int k = 0; k < A; k++) a_buf[k] <= '0;
      end else begin
         for (int k = 0; k < I; k++) begin
            if (h_fire && h_cnt == HAW'(k)) h_buf[k] <= H_row;
         end
         for (int k = 0; k < A; k++) begin
            if (a_fire && a_cnt == AAW'(k)) a_buf[k] <= alpha_u_col;
         end
      end
   end

   // Decoding against each valid index leaves out-of-range addresses at 0.
   always_comb begin
      h_rd_data = '0;
      for (int k = 0; k < I; k++) begin
         if (h_rd_addr == HAW'(k)) h_rd_data = h_buf[k];
      end
   end

   always_comb begin
      a_rd_data = '0;
      for (int k = 0; k < A; k++) begin
         if (a_rd_addr == AAW'(k)) a_rd_data = a_buf[k];
      end
   end

`ifdef RX_TLAST_CHECK_EN
   logic err_q;

   // A beat is still stored when its tlast is wrong; only the flag records it.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (state == IDLE && start) begin
         err_q <= 1'b0;
      end else begin
         if (h_fire && (H_row_tlast != (h_cnt == H_LAST))) err_q <= 1'b1;
         if (a_fire && (alpha_u_col_tlast != (a_cnt == A_LAST))) err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   logic unused_tlast;

   assign unused_tlast = H_row_tlast ^ alpha_u_col_tlast;
   assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_h_alpha_stream_rx.sv
// Scoreboard bench for h_alpha_stream_rx (J=14, I=2, A=2, DW=16).
// Stimulus drives directed beats and pushes expected frames into done_q
// (with the cycle in which frame_done must appear) and buffer snapshots
// into peek_q; the monitor pops and compares as the DUT presents them.
module tb_h_alpha_stream_rx;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [13:0]   H_row;
   logic          H_row_tvalid;
   logic          H_row_tlast;
   logic          H_row_tready;
   logic [15:0]   alpha_u_col;
   logic          alpha_u_col_tvalid;
   logic          alpha_u_col_tlast;
   logic          alpha_u_col_tready;
   logic [1:0]    h_rd_addr = 2'd0;
   logic [13:0]   h_rd_data;
   logic [1:0]    a_rd_addr = 2'd0;
   logic [15:0]   a_rd_data;
   logic          frame_done;
   logic          busy;
   logic          err;

`ifdef RX_TLAST_CHECK_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   typedef struct {
      logic [13:0] h0;
      logic [13:0] h1;
      logic [15:0] a0;
      logic [15:0] a1;
      logic        err;
      int          done_cyc;
   } exp_t;

   exp_t done_q[$];
   exp_t peek_q[$];
   exp_t pend;
   int   cyc     = 0;
   int   n_pass  = 0;
   int   n_total = 0;

   h_alpha_stream_rx #(.J(14), .I(2), .A(2), .DW(16)) dut (
      .clk                (clk),
      .rst                (rst),
      .start              (start),
      .H_row              (H_row),
      .H_row_tvalid       (H_row_tvalid),
      .H_row_tlast        (H_row_tlast),
      .H_row_tready       (H_row_tready),
      .alpha_u_col        (alpha_u_col),
      .alpha_u_col_tvalid (alpha_u_col_tvalid),
      .alpha_u_col_tlast  (alpha_u_col_tlast),
      .alpha_u_col_tready (alpha_u_col_tready),
      .h_rd_addr          (h_rd_addr),
      .h_rd_data          (h_rd_data),
      .a_rd_addr          (a_rd_addr),
      .a_rd_data          (a_rd_data),
      .frame_done         (frame_done),
      .busy               (busy),
      .err                (err)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic set_pend(input logic [13:0] h0, input logic [13:0] h1,
                           input logic [15:0] a0, input logic [15:0] a1, input logic e);
      pend.h0 = h0; pend.h1 = h1; pend.a0 = a0; pend.a1 = a1;
      pend.err = e; pend.done_cyc = 0;
   endtask

   // One cycle: drive inputs after the falling edge, check the stream-side
   // outputs for the current state, optionally register the expected frame end.
   task automatic step(input bit st, input bit rs,
                       input bit hv, input logic [13:0] hd, input bit hl,
                       input bit av, input logic [15:0] ad, input bit al,
                       input bit eht, input bit eat, input bit ebusy,
                       input bit fin, input string nm);
      exp_t e;
      @(negedge clk);
      start = st; rst = rs;
      H_row_tvalid = hv; H_row = hd; H_row_tlast = hl;
      alpha_u_col_tvalid = av; alpha_u_col = ad; alpha_u_col_tlast = al;
      #1;
      chk({nm, " H_row_tready"}, H_row_tready, eht);
      chk({nm, " alpha_tready"}, alpha_u_col_tready, eat);
      chk({nm, " busy"}, busy, ebusy);
      if (fin) begin
         e = pend;
         e.done_cyc = cyc + 1;
         done_q.push_back(e);
      end
   endtask

   // Idle one cycle with inputs held and ask the monitor for a buffer snapshot.
   task automatic peek(input logic [13:0] h0, input logic [13:0] h1,
                       input logic [15:0] a0, input logic [15:0] a1, input logic e);
      exp_t p;
      @(negedge clk);
      #1;
      p.h0 = h0; p.h1 = h1; p.a0 = a0; p.a1 = a1; p.err = e; p.done_cyc = 0;
      peek_q.push_back(p);
   endtask

   task automatic check_bufs(input exp_t e, input string nm);
      h_rd_addr = 2'd0; a_rd_addr = 2'd0; #1;
      chk({nm, " h_rd[0]"}, h_rd_data, e.h0);
      chk({nm, " a_rd[0]"}, a_rd_data, e.a0);
      h_rd_addr = 2'd1; a_rd_addr = 2'd1; #1;
      chk({nm, " h_rd[1]"}, h_rd_data, e.h1);
      chk({nm, " a_rd[1]"}, a_rd_data, e.a1);
      h_rd_addr = 2'd2; a_rd_addr = 2'd3; #1;
      chk({nm, " h_rd[2] out of range"}, h_rd_data, 0);
      chk({nm, " a_rd[3] out of range"}, a_rd_data, 0);
      chk({nm, " err"}, err, e.err);
   endtask

   // Monitor
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (frame_done) begin
         if (done_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_frame_done: got 1 expected 0 (cycle %0d)", cyc);
         end else begin
            e = done_q.pop_front();
            chk("frame_done cycle", cyc, e.done_cyc);
            check_bufs(e, "frame");
         end
      end else if (done_q.size() > 0 && cyc >= done_q[0].done_cyc) begin
         e = done_q.pop_front();
         n_total++;
         $display("FAIL missing_frame_done: got 0 expected 1 (cycle %0d)", e.done_cyc);
      end
      if (peek_q.size() > 0) begin
         e = peek_q.pop_front();
         check_bufs(e, "peek");
      end
   end

   initial begin
      rst = 1'b1; start = 1'b0;
      H_row = '0; H_row_tvalid = 1'b0; H_row_tlast = 1'b0;
      alpha_u_col = '0; alpha_u_col_tvalid = 1'b0; alpha_u_col_tlast = 1'b0;
      repeat (2) @(negedge clk);

      // reset state
      step(0,1, 0,14'h0,0, 0,16'h0,0, 0,0,0, 0, "reset");
      chk("reset frame_done", frame_done, 0);
      chk("reset err", err, 0);
      peek(14'h0, 14'h0, 16'h0, 16'h0, 1'b0);

      // rst wins over start
      step(1,1, 0,14'h0,0, 0,16'h0,0, 0,0,0, 0, "rst+start");
      step(0,0, 0,14'h0,0, 0,16'h0,0, 0,0,0, 0, "after rst+start");

      // basic frame, beats paired
      set_pend(14'h1234, 14'h0ABC, 16'h0001, 16'hFFFF, 1'b0);
      step(1,0, 0,14'h0,0,    0,16'h0,0,    0,0,0, 0, "t1 start");
      step(0,0, 1,14'h1234,0, 1,16'h0001,0, 1,1,1, 0, "t1 beat0");
      step(0,0, 1,14'h0ABC,1, 1,16'hFFFF,1, 1,1,1, 1, "t1 beat1");
      step(0,0, 0,14'h0,0,    0,16'h0,0,    0,0,1, 0, "t1 done");
      step(0,0, 0,14'h0,0,    0,16'h0,0,    0,0,0, 0, "t1 idle");

      // H first with a 3rd beat held pending, then alpha
      set_pend(14'h1111, 14'h2222, 16'h00AA, 16'h00BB, 1'b0);
      step(1,0, 0,14'h0,0,    0,16'h0,0,    0,0,0, 0, "t2 start");
      step(0,0, 1,14'h1111,0, 0,16'h0,0,    1,1,1, 0, "t2 h0");
      step(0,0, 1,14'h2222,1, 0,16'h0,0,    1,1,1, 0, "t2 h1");
      step(0,0, 1,14'h3333,0, 1,16'h00AA,0, 0,1,1, 0, "t2 a0 h3 held");
      step(0,0, 1,14'h3333,0, 1,16'h00BB,1, 0,1,1, 1, "t2 a1 h3 held");
      step(0,0, 1,14'h3333,0, 0,16'h0,0,    0,0,1, 0, "t2 done");
      step(0,0, 1,14'h3333,0, 1,16'h7777,0, 0,0,0, 0, "t2 idle valid");
      peek(14'h1111, 14'h2222, 16'h00AA, 16'h00BB, 1'b0);

      // staggered, last H and last alpha in the same cycle
      set_pend(14'h0101, 14'h0202, 16'h1010, 16'h2020, 1'b0);
      step(1,0, 0,14'h0,0,    0,16'h0,0,    0,0,0, 0, "t3 start");
      step(0,0, 1,14'h0101,0, 0,16'h0,0,    1,1,1, 0, "t3 h0");
      step(0,0, 0,14'h0,0,    1,16'h1010,0, 1,1,1, 0, "t3 a0");
      step(0,0, 1,14'h0202,1, 1,16'h2020,1, 1,1,1, 1, "t3 both last");
      step(0,0, 0,14'h0,0,    0,16'h0,0,    0,0,1, 0, "t3 done");
      step(0,0, 0,14'h0,0,    0,16'h0,0,    0,0,0, 0, "t3 idle");

      // start held during RECV is ignored
      set_pend(14'h0AAA, 14'h0BBB, 16'h5555, 16'h6666, 1'b0);
      step(1,0, 0,14'h0,0,    0,16'h0,0,    0,0,0, 0, "t4 start");
      step(1,0, 1,14'h0AAA,0, 0,16'h0,0,    1,1,1, 0, "t4 h0");
      step(1,0, 1,14'h0BBB,1, 1,16'h5555,0, 1,1,1, 0, "t4 h1 a0");
      step(1,0, 0,14'h0,0,    1,16'h6666,1, 0,1,1, 1, "t4 a1");
      step(0,0, 0,14'h0,0,    0,16'h0,0,    0,0,1, 0, "t4 done");
      step(0,0, 0,14'h0,0,    0,16'h0,0,    0,0,0, 0, "t4 idle");

      // rst mid-frame abandons it and clears the buffers
      step(1,0, 0,14'h0,0,    0,16'h0,0,    0,0,0, 0, "t5 start");
      step(0,0, 1,14'h0777,1, 0,16'h0,0,    1,1,1, 0, "t5 h0");
      step(0,1, 1,14'h0888,1, 1,16'h9999,1, 1,1,1, 0, "t5 rst");
      step(0,0, 0,14'h0,0,    0,16'h0,0,    0,0,0, 0, "t5 after rst");
      peek(14'h0, 14'h0, 16'h0, 16'h0, 1'b0);
      set_pend(14'h0123, 14'h0456, 16'hAAAA, 16'h5555, 1'b0);
      step(1,0, 0,14'h0,0,    0,16'h0,0,    0,0,0, 0, "t5 restart");
      step(0,0, 1,14'h0123,0, 1,16'hAAAA,0, 1,1,1, 0, "t5 beat0");
      step(0,0, 1,14'h0456,1, 1,16'h5555,1, 1,1,1, 1, "t5 beat1");
      step(0,0, 0,14'h0,0,    0,16'h0,0,    0,0,1, 0, "t5 done");

      // misplaced tlast: flagged only when the check is built in
      set_pend(14'h0001, 14'h0003, 16'h0002, 16'h0004, ERR_EXP);
      step(1,0, 0,14'h0,0,    0,16'h0,0,    0,0,0, 0, "t6 start");
      step(0,0, 1,14'h0001,1, 1,16'h0002,0, 1,1,1, 0, "t6 beat0");
      step(0,0, 1,14'h0003,1, 1,16'h0004,1, 1,1,1, 1, "t6 beat1");
      chk("t6 err after bad tlast", err, ERR_EXP);
      step(0,0, 0,14'h0,0,    0,16'h0,0,    0,0,1, 0, "t6 done");
      step(1,0, 0,14'h0,0,    0,16'h0,0,    0,0,0, 0, "t6 restart");
      step(0,0, 0,14'h0,0,    0,16'h0,0,    1,1,1, 0, "t6 recv");
      chk("t6 err cleared by start", err, 0);
      step(0,1, 0,14'h0,0,    0,16'h0,0,    1,1,1, 0, "t6 abort");
      step(0,0, 0,14'h0,0,    0,16'h0,0,    0,0,0, 0, "t6 idle");

      repeat (4) @(negedge clk);
      chk("done_q drained", done_q.size(), 0);
      chk("peek_q drained", peek_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
